// File: rtl/motor_ramp_driver.sv
// motor_ramp_driver: per-channel signed-power motor driver with slew-limited duty ramp, brake/dead-time reversal and shared-counter PWM
module motor_ramp_driver #(
  parameter int CHANNELS     = 2,
  parameter int PWR_W        = 16,
  parameter int DUTY_W       = 10,
  parameter int PERIOD       = 20000,
  parameter int RAMP_STEP    = 8,
  parameter int DEAD_PERIODS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [CHANNELS*PWR_W-1:0]  power,
  output logic [2*CHANNELS-1:0]      direction,
  output logic [CHANNELS-1:0]        pwm,
  output logic [CHANNELS*DUTY_W-1:0] duty,
  output logic [CHANNELS-1:0]        at_target
);
  localparam int CW = $clog2(PERIOD);
  localparam int TW = DUTY_W + CW + 1;
  localparam int DW = $clog2(DEAD_PERIODS + 1);
  localparam int SV = RAMP_STEP < 2**DUTY_W - 1 ? RAMP_STEP : 2**DUTY_W - 1;
  localparam logic [DUTY_W-1:0] STEP   = DUTY_W'(SV);
  localparam logic [DUTY_W-1:0] DMAX   = '1;
  localparam logic [PWR_W:0]    DMAX_W = (PWR_W+1)'(2**DUTY_W - 1);
  localparam logic [DW-1:0]     DEAD_N = DW'(DEAD_PERIODS);
  localparam logic [TW-1:0]     PER_T  = TW'(PERIOD);
  typedef enum logic [1:0] {RUN, RAMP_DOWN, DEAD} state_t;
  logic [CW-1:0] cnt;
  logic          bnd;
  assign bnd = cnt == CW'(PERIOD - 1);
  always_ff @(posedge clk)
    cnt <= (rst || bnd) ? '0 : cnt + 1'b1;
  for (genvar c = 0; c < CHANNELS; c++) begin : ch
    logic [PWR_W-1:0]  p;
    logic [PWR_W:0]    ext, absv;
    logic [DUTY_W-1:0] mag, duty_q, duty_n, dn, diff, stepv, tw;
    logic [1:0]        tdir, cur_dir, dir_n, dir_q;
    logic [DW-1:0]     dead_q, dead_n;
    logic [TW-1:0]     thr;
    logic              rev, pwm_q, at_q;
    state_t            state, state_n;
    assign p     = power[c*PWR_W +: PWR_W];
    assign ext   = {p[PWR_W-1], p};
    assign absv  = p[PWR_W-1] ? -ext : ext;
    assign mag   = !enable ? '0 : (absv > DMAX_W ? DMAX : absv[DUTY_W-1:0]);
    assign tdir  = p[PWR_W-1] ? 2'b01 : 2'b10;
    assign rev   = mag != '0 && tdir != cur_dir;
    assign dn    = duty_q - (duty_q > STEP ? STEP : duty_q);
    assign diff  = mag > duty_q ? mag - duty_q : duty_q - mag;
    assign stepv = diff > STEP ? STEP : diff;
    assign tw    = mag > duty_q ? duty_q + stepv : duty_q - stepv;
    assign thr   = (TW'(duty_q) * PER_T) >> DUTY_W;
    always_comb begin
      state_n = state;
      duty_n  = duty_q;
      dir_n   = cur_dir;
      dead_n  = dead_q;
      if (state == RUN) begin
        if (!rev) duty_n = tw;
        else if (duty_q == '0) begin
          state_n = DEAD;
          dead_n  = DEAD_N;
        end else begin
          state_n = RAMP_DOWN;
          duty_n  = dn;
        end
      end else if (state == RAMP_DOWN) begin
        if (!rev) state_n = RUN;
        else begin
          duty_n = dn;
          if (dn == '0) begin
            state_n = DEAD;
            dead_n  = DEAD_N;
          end
        end
      end else begin
        duty_n = '0;
        // the period that ends with cnt_dead at 1 is the last whole dead period
        if (dead_q <= DW'(1)) begin
          state_n = RUN;
          dir_n   = tdir;
        end else dead_n = dead_q - 1'b1;
      end
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        state   <= DEAD;
        dead_q  <= '0;
        duty_q  <= '0;
        cur_dir <= 2'b10;
        dir_q   <= 2'b00;
        at_q    <= 1'b0;
        pwm_q   <= 1'b0;
      end else begin
        pwm_q <= TW'(cnt) < thr;
        if (bnd) begin
          state   <= state_n;
          dead_q  <= dead_n;
          duty_q  <= duty_n;
          cur_dir <= dir_n;
          dir_q   <= state_n == DEAD ? 2'b00 : dir_n;
          at_q    <= state_n == RUN && duty_n == mag;
        end
      end
    end
    assign direction[2*c +: 2]       = dir_q;
    assign pwm[c]                    = pwm_q;
    assign duty[c*DUTY_W +: DUTY_W]  = duty_q;
    assign at_target[c]              = at_q;
  end
endmodule

// File: tb/tb_motor_ramp_driver.sv
// tb_motor_ramp_driver: directed period-by-period vectors plus reset-recovery sequences
module tb_motor_ramp_driver;
  localparam int P = 100;
  logic        clk = 0, rst = 1, enable = 1;
  logic [31:0] power = '0;
  logic [3:0]  direction;
  logic [1:0]  pwm, at_target;
  logic [19:0] duty;
  int total = 0, bad = 0, hi0 = 0;

  typedef struct {
    int p0, p1, en;
    int d0, u0, a0, h0;
    int d1, u1, a1;
  } vec_t;
  vec_t tbl[$];

  motor_ramp_driver #(.CHANNELS(2), .PWR_W(16), .DUTY_W(10), .PERIOD(P),
                      .RAMP_STEP(256), .DEAD_PERIODS(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .power(power),
    .direction(direction), .pwm(pwm), .duty(duty), .at_target(at_target));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int p0, p1, en, d0, u0, a0, h0, d1, u1, a1);
    vec_t v;
    v = '{p0, p1, en, d0, u0, a0, h0, d1, u1, a1};
    tbl.push_back(v);
  endtask

  task automatic set_in(input int p0, input int p1, input int en);
    power  = {16'(p1), 16'(p0)};
    enable = en[0];
  endtask

  task automatic period();
    hi0 = 0;
    repeat (P) begin
      @(posedge clk);
      #1;
      hi0 += int'(pwm[0]);
    end
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    chk({tag, "_dir"}, int'(direction), 0);
    chk({tag, "_duty"}, int'(duty), 0);
    chk({tag, "_pwm"}, int'(pwm), 0);
    chk({tag, "_at"}, int'(at_target), 0);
  endtask

  task automatic restart_check(input string tag);
    period();
    chk({tag, "_b1_dir0"}, int'(direction[1:0]), 2);
    chk({tag, "_b1_duty0"}, int'(duty[9:0]), 0);
    period();
    chk({tag, "_b2_duty0"}, int'(duty[9:0]), 256);
    chk({tag, "_b2_at0"}, int'(at_target[0]), 0);
    period();
    chk({tag, "_b3_duty0"}, int'(duty[9:0]), 512);
    chk({tag, "_b3_at0"}, int'(at_target[0]), 1);
  endtask

  initial begin
    //   p0      p1   en  d0  u0   a0 h0   d1  u1   a1
    add(  512, -300, 1,  2,    0, 0,  0,  1,    0, 0);
    add(  512, -300, 1,  2,  256, 0,  0,  1,  256, 0);
    add(  512, -300, 1,  2,  512, 1, 25,  1,  300, 1);
    add(  512, -300, 1,  2,  512, 1, 50,  1,  300, 1);
    add( -512, -300, 1,  2,  256, 0, 50,  1,  300, 1);
    add(  512, -300, 1,  2,  256, 0, 25,  1,  300, 1);
    add(  512, -300, 1,  2,  512, 1, 25,  1,  300, 1);
    add( -512, -300, 1,  2,  256, 0, 50,  1,  300, 1);
    add( -512, -300, 1,  0,    0, 0, 25,  1,  300, 1);
    add( -512, -300, 1,  0,    0, 0,  0,  1,  300, 1);
    add( -512, -300, 1,  1,    0, 0,  0,  1,  300, 1);
    add( -512, -300, 1,  1,  256, 0,  0,  1,  300, 1);
    add( -512, -300, 1,  1,  512, 1, 25,  1,  300, 1);
    add( 5000, -300, 1,  1,  256, 0, 50,  1,  300, 1);
    add( 5000, -300, 1,  0,    0, 0, 25,  1,  300, 1);
    add( 5000, -300, 1,  0,    0, 0,  0,  1,  300, 1);
    add( 5000, -300, 1,  2,    0, 0,  0,  1,  300, 1);
    add( 5000, -300, 1,  2,  256, 0,  0,  1,  300, 1);
    add( 5000, -300, 1,  2,  512, 0, 25,  1,  300, 1);
    add( 5000, -300, 1,  2,  768, 0, 50,  1,  300, 1);
    add( 5000, -300, 1,  2, 1023, 1, 75,  1,  300, 1);
    add(-32768, -300, 1, 2,  767, 0, 99,  1,  300, 1);
    add(-32768, -300, 1, 2,  511, 0, 74,  1,  300, 1);
    add(-32768, -300, 1, 2,  255, 0, 49,  1,  300, 1);
    add(-32768, -300, 1, 0,    0, 0, 24,  1,  300, 1);
    add(-32768, -300, 1, 0,    0, 0,  0,  1,  300, 1);
    add(-32768, -300, 1, 1,    0, 0,  0,  1,  300, 1);
    add(-32768, -300, 1, 1,  256, 0,  0,  1,  300, 1);
    add(-32768, -300, 1, 1,  512, 0, 25,  1,  300, 1);
    add(-32768, -300, 1, 1,  768, 0, 50,  1,  300, 1);
    add(-32768, -300, 1, 1, 1023, 1, 75,  1,  300, 1);
    add( -512, -300, 1,  1,  767, 0, 99,  1,  300, 1);
    add( -512, -300, 1,  1,  512, 1, 74,  1,  300, 1);
    add( -512, -300, 0,  1,  256, 0, 50,  1,   44, 0);
    add( -512, -300, 0,  1,    0, 1, 25,  1,    0, 1);
    add( -512, -300, 0,  1,    0, 1,  0,  1,    0, 1);

    set_in(512, -300, 1);
    @(posedge clk);
    #1;
    pulse_reset("reset");
    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].p0, tbl[i].p1, tbl[i].en);
      period();
      chk($sformatf("v%0d_dir0", i), int'(direction[1:0]), tbl[i].d0);
      chk($sformatf("v%0d_duty0", i), int'(duty[9:0]), tbl[i].u0);
      chk($sformatf("v%0d_at0", i), int'(at_target[0]), tbl[i].a0);
      chk($sformatf("v%0d_pwmhi0", i), hi0, tbl[i].h0);
      chk($sformatf("v%0d_dir1", i), int'(direction[3:2]), tbl[i].d1);
      chk($sformatf("v%0d_duty1", i), int'(duty[19:10]), tbl[i].u1);
      chk($sformatf("v%0d_at1", i), int'(at_target[1]), tbl[i].a1);
    end

    set_in(512, -300, 1);
    pulse_reset("rst_a");
    restart_check("run_a");
    period();
    chk("steady_pwmhi0", hi0, 50);

    pulse_reset("rst_b");
    period();
    period();
    repeat (40) @(posedge clk);
    #1;
    pulse_reset("rst_midramp");
    restart_check("run_b");

    set_in(-512, -300, 1);
    period();
    period();
    chk("pre_dead_dir0", int'(direction[1:0]), 0);
    repeat (40) @(posedge clk);
    #1;
    set_in(512, -300, 1);
    pulse_reset("rst_middead");
    restart_check("run_c");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
